// File: rtl/debug_trace_buffer.sv
// -----------------------------------------------------------------------------
// debug_trace_buffer
//
// Captures memory-mapped debug writes on NUM_CH channels, timestamps each one
// with the free-running tick counter, queues the records in a DEPTH-entry FIFO
// and serialises every record as four 32-bit beats on a valid/ready stream:
//   beat 0 : header {ADDRESS, ovf, 8'h00, ch[6:0]}
//   beat 1 : captured write data
//   beat 2 : timestamp[31:0]
//   beat 3 : timestamp[63:32] (zero-extended), trace_last_o high
//
// Bus register map (en_i && we_i):
//   0x000004         : set sticky halt request
//   0x000008         : channel enable mask (low 32 mask bits only)
//   CH_BASE + 4*k    : capture channel k (k < NUM_CH)
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   en_i/we_i       bus access enable / write
//   addr_i          bus byte address (24 bit)
//   data_i          bus write data (32 bit)
//   tick_cntr_i     free-running tick counter (TS_WIDTH bit)
//   trace_valid_o   stream beat valid
//   trace_ready_i   stream beat accept
//   trace_data_o    stream beat data
//   trace_last_o    final beat of a record
//   halt_o          halt requested and trace fully drained (sticky)
//   overflow_cnt_o  saturating count of records dropped on a full FIFO
//   level_o         FIFO occupancy
// -----------------------------------------------------------------------------
module debug_trace_buffer #(
   parameter logic [15:0] ADDRESS  = 16'h0000,
   parameter int          NUM_CH   = 8,
   parameter int          DEPTH    = 16,
   parameter int          TS_WIDTH = 64,
   parameter logic [23:0] CH_BASE  = 24'h000020
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     en_i,
   input  logic                     we_i,
   input  logic [23:0]              addr_i,
   input  logic [31:0]              data_i,
   input  logic [TS_WIDTH-1:0]      tick_cntr_i,
   output logic                     trace_valid_o,
   input  logic                     trace_ready_i,
   output logic [31:0]              trace_data_o,
   output logic                     trace_last_o,
   output logic                     halt_o,
   output logic [15:0]              overflow_cnt_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW        = $clog2(DEPTH);
   localparam int CNT_W     = AW + 1;
   localparam int REC_W     = 104;          // ovf(1) + ch(7) + data(32) + ts(64)
   localparam int MASK_WR_W = (NUM_CH < 32) ? NUM_CH : 32;

   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [21:0]      NUM_CH_C  = 22'(NUM_CH);
   localparam logic [23:0]      HALT_ADDR = 24'h000004;
   localparam logic [23:0]      MASK_ADDR = 24'h000008;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_DAT  = 3'd2,
      S_TSL  = 3'd3,
      S_TSH  = 3'd4
   } state_t;

   // Header beat built from a stored record (ovf and channel live in the top bits).
   function automatic logic [31:0] hdr_word(input logic [REC_W-1:0] rec);
      return {ADDRESS, rec[103], 8'h00, rec[102:96]};
   endfunction

   // ---------------------------------------------------------------- state
   state_t                 state_r;
   logic [NUM_CH-1:0]      mask_r;
   logic                   halt_req_r;
   logic                   ovf_pend_r;
   logic [AW-1:0]          wr_ptr_r;
   logic [AW-1:0]          rd_ptr_r;
   logic [CNT_W-1:0]       count_r;
   logic [95:0]            rec_r;          // data + timestamp of the record in flight
   logic [REC_W-1:0]       mem_r [DEPTH];

   // ---------------------------------------------------------------- comb
   logic                   wr_s;
   logic                   halt_wr_s;
   logic                   mask_wr_s;
   logic [23:0]            ch_off_s;
   logic                   ch_hit_s;
   logic [6:0]             ch_idx_s;
   logic [127:0]           mask_ext_s;
   logic [NUM_CH-1:0]      mask_next_s;
   logic [63:0]            ts_ext_s;
   logic                   cap_ok_s;
   logic                   empty_s;
   logic                   full_s;
   logic                   pop_s;
   logic                   push_s;
   logic                   rej_s;
   logic [REC_W-1:0]       new_rec_s;
   logic [REC_W-1:0]       head_rec_s;

   assign level_o = count_r;

   // Bus address decode: halt, mask and channel-window hits.
   always_comb begin
      wr_s      = en_i && we_i;
      halt_wr_s = wr_s && (addr_i == HALT_ADDR);
      mask_wr_s = wr_s && (addr_i == MASK_ADDR);
      ch_off_s  = addr_i - CH_BASE;
      ch_idx_s  = ch_off_s[8:2];
      if (wr_s && !halt_wr_s && !mask_wr_s && (addr_i >= CH_BASE) &&
          (ch_off_s[1:0] == 2'b00) && (ch_off_s[23:2] < NUM_CH_C)) begin
         ch_hit_s = 1'b1;
      end else begin
         ch_hit_s = 1'b0;
      end
   end

   // Widened mask/timestamp views and the next mask value (bits >= 32 keep their value).
   always_comb begin
      mask_ext_s = {128{1'b0}};
      mask_ext_s[NUM_CH-1:0] = mask_r;
      ts_ext_s = {64{1'b0}};
      ts_ext_s[TS_WIDTH-1:0] = tick_cntr_i;
      mask_next_s = mask_r;
      for (int i = 0; i < MASK_WR_W; i++) begin
         mask_next_s[i] = data_i[i];
      end
   end

   // Push/pop arbitration; a full FIFO still accepts when the serializer pops this cycle.
   always_comb begin
      empty_s    = (count_r == {CNT_W{1'b0}});
      full_s     = (count_r == DEPTH_C);
      cap_ok_s   = ch_hit_s && mask_ext_s[ch_idx_s] && !halt_req_r;
      head_rec_s = mem_r[rd_ptr_r];
      new_rec_s  = {ovf_pend_r, ch_idx_s, data_i, ts_ext_s};
      // Valid is always high in HDR..TSH, so ready alone marks the TSH handshake.
      if (!empty_s && ((state_r == S_IDLE) || ((state_r == S_TSH) && trace_ready_i))) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
      push_s = cap_ok_s && (!full_s || pop_s);
      rej_s  = cap_ok_s && !push_s;
   end

   // Record storage (no reset needed: occupancy is tracked by the pointers/count).
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= new_rec_s;
      end
   end

   // FIFO pointers, occupancy, pending-overflow flag and saturating drop counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r       <= {AW{1'b0}};
         rd_ptr_r       <= {AW{1'b0}};
         count_r        <= {CNT_W{1'b0}};
         ovf_pend_r     <= 1'b0;
         overflow_cnt_o <= 16'h0000;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
         // The accepted record has already sampled the flag into its ovf bit.
         if (push_s) begin
            ovf_pend_r <= 1'b0;
         end else if (rej_s) begin
            ovf_pend_r <= 1'b1;
         end
         if (rej_s && (overflow_cnt_o != 16'hFFFF)) begin
            overflow_cnt_o <= overflow_cnt_o + 16'h0001;
         end
      end
   end

   // Channel mask, sticky halt request and drained-halt indication.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mask_r     <= {NUM_CH{1'b1}};
         halt_req_r <= 1'b0;
         halt_o     <= 1'b0;
      end else begin
         if (mask_wr_s) begin
            mask_r <= mask_next_s;
         end
         if (halt_wr_s) begin
            halt_req_r <= 1'b1;
         end
         if (halt_req_r && empty_s && (state_r == S_IDLE)) begin
            halt_o <= 1'b1;
         end
      end
   end

   // Serializer FSM: each state holds its beat until handshake, TSH chains into the next record.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r       <= S_IDLE;
         trace_valid_o <= 1'b0;
         trace_data_o  <= 32'h0000_0000;
         trace_last_o  <= 1'b0;
         rec_r         <= {96{1'b0}};
      end else begin
         case (state_r)
            S_IDLE: begin
               if (pop_s) begin
                  rec_r         <= head_rec_s[95:0];
                  trace_data_o  <= hdr_word(head_rec_s);
                  trace_valid_o <= 1'b1;
                  trace_last_o  <= 1'b0;
                  state_r       <= S_HDR;
               end
            end
            S_HDR: begin
               if (trace_valid_o && trace_ready_i) begin
                  trace_data_o <= rec_r[95:64];
                  state_r      <= S_DAT;
               end
            end
            S_DAT: begin
               if (trace_valid_o && trace_ready_i) begin
                  trace_data_o <= rec_r[31:0];
                  state_r      <= S_TSL;
               end
            end
            S_TSL: begin
               if (trace_valid_o && trace_ready_i) begin
                  trace_data_o <= rec_r[63:32];
                  trace_last_o <= 1'b1;
                  state_r      <= S_TSH;
               end
            end
            S_TSH: begin
               if (trace_valid_o && trace_ready_i) begin
                  if (pop_s) begin
                     rec_r         <= head_rec_s[95:0];
                     trace_data_o  <= hdr_word(head_rec_s);
                     trace_valid_o <= 1'b1;
                     trace_last_o  <= 1'b0;
                     state_r       <= S_HDR;
                  end else begin
                     trace_data_o  <= 32'h0000_0000;
                     trace_valid_o <= 1'b0;
                     trace_last_o  <= 1'b0;
                     state_r       <= S_IDLE;
                  end
               end
            end
            default: begin
               trace_valid_o <= 1'b0;
               trace_last_o  <= 1'b0;
               state_r       <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Scoreboard bench for debug_trace_buffer: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted stream beat.
module tb_debug_trace_buffer;

   logic        clk;
   logic        rst;
   logic        en;
   logic        we;
   logic [23:0] addr;
   logic [31:0] data;
   logic [63:0] tick;
   logic        ready;
   logic        valid;
   logic [31:0] tdata;
   logic        tlast;
   logic        halt;
   logic [15:0] ovf_cnt;
   logic [4:0]  level;

   int tests_run = 0;
   int fails     = 0;
   logic [32:0] sb[$];            // {last, data}

   debug_trace_buffer dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .en_i           (en),
      .we_i           (we),
      .addr_i         (addr),
      .data_i         (data),
      .tick_cntr_i    (tick),
      .trace_valid_o  (valid),
      .trace_ready_i  (ready),
      .trace_data_o   (tdata),
      .trace_last_o   (tlast),
      .halt_o         (halt),
      .overflow_cnt_o (ovf_cnt),
      .level_o        (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: a beat seen valid&&ready at negedge is accepted at the next posedge.
   always @(negedge clk) begin
      if (!rst && valid && ready) begin
         tests_run++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got data=0x%08h last=%0b, expected no beat", tdata, tlast);
         end else begin
            logic [32:0] e;
            e = sb.pop_front();
            if ({tlast, tdata} !== e) begin
               fails++;
               $display("FAIL beat: got data=0x%08h last=%0b, expected data=0x%08h last=%0b",
                        tdata, tlast, e[31:0], e[32]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_record(input logic [6:0] ch, input logic ovf,
                                input logic [31:0] d, input logic [63:0] ts);
      sb.push_back({1'b0, 16'h0000, ovf, 8'h00, ch});
      sb.push_back({1'b0, d});
      sb.push_back({1'b0, ts[31:0]});
      sb.push_back({1'b1, ts[63:32]});
   endtask

   // Called at posedge+1; the write is sampled at the next posedge.
   task automatic bus_wr(input logic [23:0] a, input logic [31:0] d, input logic [63:0] t);
      en = 1'b1; we = 1'b1; addr = a; data = d; tick = t;
      @(posedge clk); #1;
      en = 1'b0; we = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic wait_valid(input string name);
      int g = 0;
      while (!valid && g < 50) begin
         @(posedge clk); #1;
         g++;
      end
      check(name, valid, 1'b1);
   endtask

   task automatic wait_drain(input string name);
      int g = 0;
      while ((sb.size() != 0 || valid) && g < 300) begin
         @(posedge clk); #1;
         g++;
      end
      check(name, (g < 300), 1'b1);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; we = 1'b0; addr = 24'h0; data = 32'h0; tick = 64'h0; ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_valid", valid, 1'b0);
      check("rst_last", tlast, 1'b0);
      check("rst_level", level, 5'd0);
      check("rst_ovf", ovf_cnt, 16'h0);
      check("rst_halt", halt, 1'b0);

      // Single capture, latency N+2
      ready = 1'b1;
      expect_record(7'd1, 1'b0, 32'hDEADBEEF, 64'h1_0000_0005);
      bus_wr(24'h000024, 32'hDEADBEEF, 64'h1_0000_0005);
      check("lat_n1_valid", valid, 1'b0);
      @(posedge clk); #1;
      check("lat_n2_valid", valid, 1'b1);
      check("lat_n2_hdr", tdata, 32'h0000_0001);
      wait_drain("drain_single");

      // Backpressure at DAT
      ready = 1'b0;
      expect_record(7'd1, 1'b0, 32'hDEADBEEF, 64'h2_0000_0010);
      bus_wr(24'h000024, 32'hDEADBEEF, 64'h2_0000_0010);
      wait_valid("bp_hdr_valid");
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("bp_hold_data", tdata, 32'hDEADBEEF);
         check("bp_hold_valid", valid, 1'b1);
         @(posedge clk); #1;
      end
      ready = 1'b1;
      wait_drain("drain_bp");

      // Overflow: serializer stalled on a blocker record, 20 writes to ch0
      ready = 1'b0;
      expect_record(7'd2, 1'b0, 32'hB10C0001, 64'h5_0000_0001);
      bus_wr(24'h000028, 32'hB10C0001, 64'h5_0000_0001);
      wait_valid("ovf_blocker_valid");
      for (int i = 0; i < 20; i++) begin
         if (i < 16) expect_record(7'd0, 1'b0, 32'h1000_0000 + i, 64'h100 + i);
         bus_wr(24'h000020, 32'h1000_0000 + i, 64'h100 + i);
      end
      check("ovf_level", level, 5'd16);
      check("ovf_count", ovf_cnt, 16'd4);
      ready = 1'b1;
      wait_drain("drain_ovf");
      expect_record(7'd0, 1'b1, 32'hE0E0E0E0, 64'h7);
      bus_wr(24'h000020, 32'hE0E0E0E0, 64'h7);
      expect_record(7'd0, 1'b0, 32'hE1E1E1E1, 64'h8);
      bus_wr(24'h000020, 32'hE1E1E1E1, 64'h8);
      wait_drain("drain_ovf_flag");

      // Full FIFO with a write in the TSH-pop cycle
      ready = 1'b0;
      expect_record(7'd2, 1'b0, 32'hB10C0002, 64'h5_0000_0002);
      bus_wr(24'h000028, 32'hB10C0002, 64'h5_0000_0002);
      wait_valid("full_blocker_valid");
      for (int i = 0; i < 16; i++) begin
         expect_record(7'd0, 1'b0, 32'h2000_0000 + i, 64'h200 + i);
         bus_wr(24'h000020, 32'h2000_0000 + i, 64'h200 + i);
      end
      check("full_level", level, 5'd16);
      ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      expect_record(7'd3, 1'b0, 32'h5151_5151, 64'h9);
      bus_wr(24'h00002C, 32'h5151_5151, 64'h9);
      check("full_pop_level", level, 5'd16);
      check("full_pop_ovf", ovf_cnt, 16'd4);
      wait_drain("drain_full");

      // Reset in the middle of a record
      ready = 1'b0;
      bus_wr(24'h000028, 32'h0BAD0BAD, 64'h3);
      wait_valid("mid_rst_valid");
      do_reset();
      check("mid_rst_valid_low", valid, 1'b0);
      check("mid_rst_level", level, 5'd0);
      check("mid_rst_ovf", ovf_cnt, 16'h0);
      ready = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
      end
      check("mid_rst_no_beats", valid, 1'b0);

      // Channel mask
      bus_wr(24'h000008, 32'h0000_0002, 64'h0);
      bus_wr(24'h000020, 32'h1111_1111, 64'h6);
      expect_record(7'd1, 1'b0, 32'h2222_2222, 64'h3_0000_0007);
      bus_wr(24'h000024, 32'h2222_2222, 64'h3_0000_0007);
      wait_drain("drain_mask");
      check("mask_ovf", ovf_cnt, 16'h0);
      check("mask_level", level, 5'd0);

      // Halt after three queued records
      bus_wr(24'h000008, 32'h0000_00FF, 64'h0);
      ready = 1'b0;
      expect_record(7'd0, 1'b0, 32'hA0, 64'h40);
      bus_wr(24'h000020, 32'hA0, 64'h40);
      expect_record(7'd1, 1'b0, 32'hA1, 64'h41);
      bus_wr(24'h000024, 32'hA1, 64'h41);
      expect_record(7'd2, 1'b0, 32'hA2, 64'h42);
      bus_wr(24'h000028, 32'hA2, 64'h42);
      bus_wr(24'h000004, 32'h0, 64'h0);
      bus_wr(24'h000024, 32'hDEAD0001, 64'h43);
      check("halt_level", level, 5'd2);
      check("halt_drop_ovf", ovf_cnt, 16'h0);
      check("halt_not_yet", halt, 1'b0);
      ready = 1'b1;
      begin
         int g = 0;
         logic early = 1'b0;
         while (sb.size() != 0 && g < 200) begin
            if (halt !== 1'b0) early = 1'b1;
            @(posedge clk); #1;
            g++;
         end
         check("halt_drain_done", (g < 200), 1'b1);
         check("halt_low_while_draining", early, 1'b0);
      end
      check("halt_low_after_last", halt, 1'b0);
      @(posedge clk); #1;
      check("halt_rise", halt, 1'b1);
      check("halt_valid_low", valid, 1'b0);
      check("halt_level_empty", level, 5'd0);
      do_reset();
      check("halt_cleared", halt, 1'b0);

      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/debug_trace_buffer.md
Name: debug_trace_buffer

Overview:
- Synthesizable successor to the simulation-only PE debug sink.
- Captures memory-mapped debug writes on NUM_CH parametrised channels and timestamps each with the tick counter.
- Buffers records in a DEPTH-entry FIFO and serialises them as 4-beat 32-bit records on a valid/ready trace stream.
- Adds a per-channel enable mask, overflow accounting and a drain-then-halt indication; sits beside the PE bus, stream goes to the trace aggregator.

Parameters:
- ADDRESS, 16'h0000, PE address embedded in every record header.
- NUM_CH, 8, number of capture channels (1..128).
- DEPTH, 16, FIFO records (power of 2, >=2).
- TS_WIDTH, 64, timestamp width (33..64); zero-extended to 64 on output.
- CH_BASE, 24'h000020, byte address of channel 0; channel k at CH_BASE+4*k.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- en_i  in  1  bus access enable.
- we_i  in  1  bus write.
- addr_i  in  24  bus byte address.
- data_i  in  32  bus write data.
- tick_cntr_i  in  TS_WIDTH  free-running tick counter.
- trace_valid_o  out  1  stream beat valid.
- trace_ready_i  in  1  stream beat accept.
- trace_data_o  out  32  stream beat data.
- trace_last_o  out  1  final beat of a record.
- halt_o  out  1  halt requested and trace fully drained.
- overflow_cnt_o  out  16  dropped-record count, saturating.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: all outputs 0, mask all ones, FIFO empty, halt request cleared, pending-overflow flag cleared, FSM IDLE.
- Bus decode (en_i && we_i):
  - 0x000004: set sticky halt request.
  - 0x000008: mask <= data_i[NUM_CH-1:0]; bits above 32 are unaffected.
  - CH_BASE+4*k with k<NUM_CH: capture channel k. Other addresses are ignored.
- Capture:
  - Record = {k, data_i, tick_cntr_i sampled in the write cycle}.
  - Dropped silently, with no overflow count, if mask[k]==0 or a halt request is already set.
- Push rule: accepted if !full || pop_this_cycle; visible in level_o next cycle.
- Overflow:
  - A rejected push increments overflow_cnt_o, saturating at 16'hFFFF, and sets the pending-overflow flag.
  - The next accepted record stores ovf=1 and clears the flag in the same cycle.
- Header word: {ADDRESS[15:0], ovf, 8'b0, ch[6:0]}.
- Beats: 0 = header; 1 = data; 2 = ts[31:0]; 3 = ts[63:32], zero-extended. trace_last_o is high only on beat 3.
- Serializer FSM: IDLE, HDR, DAT, TSL, TSH; outputs are registered.
  - IDLE: if FIFO non-empty, pop into the record register and go to HDR; trace_valid_o is high from HDR on.
  - Each state holds trace_data_o/valid stable until trace_valid_o && trace_ready_i, then advances.
  - TSH handshake: if FIFO non-empty, pop and go directly to HDR (no bubble); else go to IDLE with valid low.
- Latency: capture write in cycle N -> header valid in cycle N+2 when the FSM is idle. With ready held high, sustained throughput is one record per 4 cycles.
- halt_o: rises the cycle after halt request && FIFO empty && FSM IDLE; sticky until reset.
- Reset mid-record: the record is discarded; no partial beats are emitted after reset.
- level_o never exceeds DEPTH. Pointers wrap modulo DEPTH; full/empty are derived from the count.

Test Plan:
- Single capture: write 0xDEADBEEF to 0x000024 (ch1) with tick=0x1_0000_0005, ready=1 -> beats 0x00000001, 0xDEADBEEF, 0x00000005, 0x00000001; valid at N+2; last only on beat 4.
- Backpressure: ready=0 for 10 cycles mid-record (at DAT) -> trace_data_o holds 0xDEADBEEF, valid stays high; record completes unchanged once ready=1.
- Overflow: ready=0, DEPTH=16, 20 writes to ch0 -> level_o=16, overflow_cnt_o=4. Drain, then write 1 more record -> its header has bit 15 set; the following record has bit 15 clear.
- Full with simultaneous pop: FIFO full, write in the cycle the FSM pops -> accepted, overflow_cnt_o unchanged, level_o stays 16.
- Mask: write 0x000008=0x00000002, then writes to ch0 and ch1 -> only the ch1 record is emitted; overflow_cnt_o=0.
- Halt: 3 records queued, ready=1, write 0x000004, then a ch1 write -> 3 records emitted, ch1 write dropped, halt_o rises one cycle after the last TSH handshake; rst_i pulse clears halt_o.
